// File: rtl/pc_unit.sv
// Program-counter unit: holds the fetch PC and picks the next one from sequential step,
// branch, trap entry (direct/vectored) or mret, with a one-entry redirect buffer for stalls.
module pc_unit #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     IALIGN       = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            instr_len16,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  input  logic            trap_req,
  input  logic            trap_is_irq,
  input  logic [4:0]      trap_cause,
  input  logic [XLEN-1:0] mtvec,
  input  logic            mret_req,
  input  logic [XLEN-1:0] mepc,
  output logic [XLEN-1:0] pc_out,
  output logic            pc_valid,
  output logic            misalign_exc,
  output logic [XLEN-1:0] misalign_addr,
  output logic            redirect_pending
);

  typedef enum logic [1:0] {StBoot, StRun, StHeld} state_e;

  // Buffered-request priority; zero means no request
  localparam logic [1:0] PrioNone = 2'd0;
  localparam logic [1:0] PrioBr   = 2'd1;
  localparam logic [1:0] PrioMret = 2'd2;
  localparam logic [1:0] PrioTrap = 2'd3;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic              valid_q, valid_d;
  logic              exc_q, exc_d;
  logic [XLEN-1:0]   exc_addr_q, exc_addr_d;
  logic              pending_q, pending_d;
  logic [XLEN-1:0]   buf_tgt_q, buf_tgt_d;
  logic [1:0]        buf_prio_q, buf_prio_d;

  logic [XLEN-1:0]   trap_base, trap_tgt, mret_tgt, br_tgt, seq_tgt;
  logic              br_mis, br_mis_win;
  logic [1:0]        req_prio;
  logic [XLEN-1:0]   req_tgt;

  always_comb begin
    trap_base = {mtvec[XLEN-1:2], 2'b00};
    if (mtvec[1:0] == 2'b01 && trap_is_irq) begin
      trap_tgt = trap_base + {{(XLEN-7){1'b0}}, trap_cause, 2'b00};
    end else begin
      trap_tgt = trap_base;
    end
    mret_tgt = (IALIGN == 32) ? {mepc[XLEN-1:2], 2'b00} : {mepc[XLEN-1:1], 1'b0};
    br_tgt   = {br_target[XLEN-1:1], 1'b0};
    br_mis   = (IALIGN == 32) && br_target[1];
    seq_tgt  = pc_q + ((IALIGN == 16 && instr_len16) ? {{(XLEN-3){1'b0}}, 3'd2}
                                                     : {{(XLEN-3){1'b0}}, 3'd4});
    br_mis_win = br_taken && br_mis && !trap_req && !mret_req;

    // Winning redirect request; a misaligned branch never becomes a redirect
    if (trap_req) begin
      req_prio = PrioTrap;
      req_tgt  = trap_tgt;
    end else if (mret_req) begin
      req_prio = PrioMret;
      req_tgt  = mret_tgt;
    end else if (br_taken && !br_mis) begin
      req_prio = PrioBr;
      req_tgt  = br_tgt;
    end else begin
      req_prio = PrioNone;
      req_tgt  = '0;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    exc_d      = 1'b0;
    exc_addr_d = exc_addr_q;
    buf_tgt_d  = buf_tgt_q;
    buf_prio_d = buf_prio_q;

    case (state_q)
      StBoot: state_d = StRun;
      StRun: begin
        if (br_mis_win) begin
          exc_d      = 1'b1;
          exc_addr_d = br_target;
        end else if (stall) begin
          if (req_prio != PrioNone) begin
            buf_tgt_d  = req_tgt;
            buf_prio_d = req_prio;
            state_d    = StHeld;
          end
        end else if (req_prio != PrioNone) begin
          pc_d = req_tgt;
        end else begin
          pc_d = seq_tgt;
        end
      end
      StHeld: begin
        if (stall) begin
          if (req_prio > buf_prio_q) begin
            buf_tgt_d  = req_tgt;
            buf_prio_d = req_prio;
          end
        end else begin
          pc_d       = trap_req ? trap_tgt : buf_tgt_q;
          buf_prio_d = PrioNone;
          state_d    = StRun;
        end
      end
      default: state_d = StBoot;
    endcase

    valid_d   = (state_d != StBoot);
    pending_d = (state_d == StHeld);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StBoot;
      pc_q       <= RESET_VECTOR;
      valid_q    <= 1'b0;
      exc_q      <= 1'b0;
      exc_addr_q <= '0;
      pending_q  <= 1'b0;
      buf_tgt_q  <= '0;
      buf_prio_q <= PrioNone;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      exc_q      <= exc_d;
      exc_addr_q <= exc_addr_d;
      pending_q  <= pending_d;
      buf_tgt_q  <= buf_tgt_d;
      buf_prio_q <= buf_prio_d;
    end
  end

  assign pc_out           = pc_q;
  assign pc_valid         = valid_q;
  assign misalign_exc     = exc_q;
  assign misalign_addr    = exc_addr_q;
  assign redirect_pending = pending_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: one IALIGN=32 and one IALIGN=16 instance share the stimulus.
module tb_pc_unit;

  localparam logic [31:0] Rv = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst, stall, instr_len16, br_taken, trap_req, trap_is_irq, mret_req;
  logic [31:0] br_target, mtvec, mepc;
  logic [4:0]  trap_cause;

  logic [31:0] a_pc, a_addr, b_pc, b_addr;
  logic        a_valid, a_exc, a_pend, b_valid, b_exc, b_pend;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  pc_unit #(.XLEN(32), .RESET_VECTOR(Rv), .IALIGN(32)) u_a (
    .clk(clk), .rst(rst), .stall(stall), .instr_len16(instr_len16),
    .br_taken(br_taken), .br_target(br_target), .trap_req(trap_req),
    .trap_is_irq(trap_is_irq), .trap_cause(trap_cause), .mtvec(mtvec),
    .mret_req(mret_req), .mepc(mepc), .pc_out(a_pc), .pc_valid(a_valid),
    .misalign_exc(a_exc), .misalign_addr(a_addr), .redirect_pending(a_pend)
  );

  pc_unit #(.XLEN(32), .RESET_VECTOR(Rv), .IALIGN(16)) u_b (
    .clk(clk), .rst(rst), .stall(stall), .instr_len16(instr_len16),
    .br_taken(br_taken), .br_target(br_target), .trap_req(trap_req),
    .trap_is_irq(trap_is_irq), .trap_cause(trap_cause), .mtvec(mtvec),
    .mret_req(mret_req), .mepc(mepc), .pc_out(b_pc), .pc_valid(b_valid),
    .misalign_exc(b_exc), .misalign_addr(b_addr), .redirect_pending(b_pend)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 0; instr_len16 = 0; br_taken = 0; trap_req = 0; trap_is_irq = 0;
    mret_req = 0; br_target = '0; trap_cause = '0; mtvec = '0; mepc = '0;
  endtask

  initial begin
    idle();
    rst = 1;
    step(); step();
    check("rst_pc", a_pc, Rv);
    check("rst_valid", {31'd0, a_valid}, 32'd0);
    check("rst_pend", {31'd0, a_pend}, 32'd0);
    check("rst_exc", {31'd0, a_exc}, 32'd0);
    check("rst_addr", a_addr, 32'd0);
    rst = 0;
    #1;
    check("boot_valid", {31'd0, a_valid}, 32'd0);
    step();
    check("run_valid", {31'd0, a_valid}, 32'd1);
    check("run_pc0", a_pc, Rv);
    step();
    check("run_pc4", a_pc, Rv + 32'd4);
    step();
    check("run_pc8", a_pc, Rv + 32'd8);

    // Trap beats branch, direct mode
    trap_req = 1; br_taken = 1; br_target = 32'h500; mtvec = 32'h100;
    step();
    check("trap_direct", a_pc, 32'h100);
    // Vectored interrupt, cause 7
    idle(); trap_req = 1; mtvec = 32'h101; trap_is_irq = 1; trap_cause = 5'd7;
    step();
    check("trap_vec_irq", a_pc, 32'h11C);
    // Vectored mode but synchronous exception goes to base
    trap_is_irq = 0;
    step();
    check("trap_vec_exc", a_pc, 32'h100);
    // mret beats branch; bit1 kept only with IALIGN=16
    idle(); mret_req = 1; mepc = 32'h403; br_taken = 1; br_target = 32'h600;
    step();
    check("mret_a", a_pc, 32'h400);
    check("mret_b", b_pc, 32'h402);

    // Stall buffering: branch, then higher-priority mret, then a branch that must not replace
    idle(); stall = 1; br_taken = 1; br_target = 32'h200;
    step();
    check("stall_hold1", a_pc, 32'h400);
    check("stall_pend1", {31'd0, a_pend}, 32'd1);
    idle(); stall = 1; mret_req = 1; mepc = 32'h300;
    step();
    check("stall_hold2", a_pc, 32'h400);
    idle(); stall = 1; br_taken = 1; br_target = 32'h700;
    step();
    check("stall_hold3", a_pc, 32'h400);
    check("stall_pend3", {31'd0, a_pend}, 32'd1);
    idle();
    step();
    check("release_pc", a_pc, 32'h300);
    check("release_pend", {31'd0, a_pend}, 32'd0);
    step();
    check("after_release", a_pc, 32'h304);

    // Trap at release wins over the buffer
    stall = 1; br_taken = 1; br_target = 32'h200;
    step();
    idle(); trap_req = 1; mtvec = 32'h100;
    step();
    check("release_trap", a_pc, 32'h100);

    // Misalignment
    idle(); br_taken = 1; br_target = 32'h1002;
    step();
    check("mis_pc_a", a_pc, 32'h100);
    check("mis_exc_a", {31'd0, a_exc}, 32'd1);
    check("mis_addr_a", a_addr, 32'h1002);
    check("mis_pc_b", b_pc, 32'h1002);
    check("mis_exc_b", {31'd0, b_exc}, 32'd0);
    idle();
    step();
    check("mis_pulse_end", {31'd0, a_exc}, 32'd0);
    check("mis_addr_hold", a_addr, 32'h1002);
    check("mis_seq_a", a_pc, 32'h104);

    // Misaligned branch under stall: exception, nothing buffered
    stall = 1; br_taken = 1; br_target = 32'h1006;
    step();
    check("mis_stall_exc", {31'd0, a_exc}, 32'd1);
    check("mis_stall_pend", {31'd0, a_pend}, 32'd0);
    check("mis_stall_b_pend", {31'd0, b_pend}, 32'd1);
    idle();
    step();

    // Wrap and compressed stepping
    br_taken = 1; br_target = 32'hFFFF_FFFC;
    step();
    check("wrap_setup_b", b_pc, 32'hFFFF_FFFC);
    idle();
    step();
    check("wrap_a", a_pc, 32'h0);
    check("wrap_b", b_pc, 32'h0);
    instr_len16 = 1;
    step();
    check("c_step_b", b_pc, 32'h2);
    check("c_ignored_a", a_pc, 32'h4);

    // Reset while HELD
    idle(); stall = 1; br_taken = 1; br_target = 32'h900;
    step();
    check("held_pend", {31'd0, a_pend}, 32'd1);
    idle(); stall = 1; rst = 1;
    step();
    check("held_rst_pc", a_pc, Rv);
    check("held_rst_pend", {31'd0, a_pend}, 32'd0);
    rst = 0; stall = 0;
    step();
    check("held_rst_boot", a_pc, Rv);
    step();
    check("held_rst_seq", a_pc, Rv + 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
